rmt_dest_demux: RTL and testbench
=================================

# rmt_dest_demux

Downstream stage of the match-action filter in the template app datapath. It takes the single filtered AXI-Stream, which carries a per-frame `tdest`, and steers each whole frame to one of `M_COUNT` output streams. Frames whose destination is out of range are discarded. The block adds one registered output stage, with no bubble between back-to-back frames.

## Interface
- `DATA_WIDTH`, 512: tdata width in bits.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `USER_WIDTH`, 8: tuser width.
- `DEST_WIDTH`, 2: tdest width.
- `M_COUNT`, 3: number of output ports; legal destinations are 0..`M_COUNT`-1.
- `CNT_WIDTH`, 32: statistics counter width.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in `DATA_WIDTH`: input data.
- `s_axis_tkeep` in `KEEP_WIDTH`: input byte enables.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input beat accepted.
- `s_axis_tlast` in 1: last beat of frame.
- `s_axis_tuser` in `USER_WIDTH`: input sideband.
- `s_axis_tdest` in `DEST_WIDTH`: destination; meaningful on first beat only.
- `m_axis_tdata` out `M_COUNT*DATA_WIDTH`: per-port data; all ports carry the same value.
- `m_axis_tkeep` out `M_COUNT*KEEP_WIDTH`: per-port byte enables; same value on all ports.
- `m_axis_tvalid` out `M_COUNT`: per-port valid; at most one bit set at a time.
- `m_axis_tready` in `M_COUNT`: per-port ready.
- `m_axis_tlast` out `M_COUNT`: per-port last.
- `m_axis_tuser` out `M_COUNT*USER_WIDTH`: per-port sideband.
- `stat_frames` out `M_COUNT*CNT_WIDTH`: frames delivered per port (see Configuration).
- `stat_drops` out `CNT_WIDTH`: frames discarded (see Configuration).

## Operation
- Frame FSM states: IDLE, FWD, DROP. Reset enters IDLE.
- IDLE, first beat accepted:
  - `s_axis_tdest` < `M_COUNT`: latch it into `sel_reg`, load the output register, go to FWD.
  - Otherwise: discard the beat and go to DROP.
  - If `tlast` is also set on that beat, stay in IDLE.
- FWD: each accepted beat loads the output register, tagged with `sel_reg`. The accepted `tlast` beat returns the FSM to IDLE.
- DROP: each accepted beat is discarded. The accepted `tlast` beat returns the FSM to IDLE.
- `s_axis_tdest` on non-first beats is ignored.
- Output register holds: data, keep, last, user, port tag `out_sel`, and `out_valid`.
  - `m_axis_tvalid[i] = out_valid && (out_sel == i)`.
  - Data, keep and user are broadcast to all ports.
  - `m_axis_tlast[i]` is gated like tvalid.
- Ready rule:
  - `s_axis_tready = !out_valid || m_axis_tready[out_sel]`, in all states.
  - Discarded beats still wait for the output register to drain. This keeps ordering simple, with no separate fast path.
- Register update:
  - A beat loads when `s_axis_tvalid && s_axis_tready` and the beat is forwarded.
  - Otherwise `out_valid` clears when the output handshake completes.
- Any output port may stall indefinitely. The input then stalls; other ports receive nothing.

## Timing
- Latency: 1 cycle from input acceptance to `m_axis_tvalid`.
- Throughput: 1 beat per cycle while the selected port is ready.
- Back-to-back frames to different ports: the last beat of frame A is consumed in the same cycle that the first beat of frame B loads. No bubble.
- Reset values:
  - All `m_axis_*` outputs 0.
  - `s_axis_tready` 0 while `rst_n` is low; equal to 1 on the first cycle after release.
  - State IDLE, `out_valid` 0, counters 0.
- Reset mid-frame: the in-flight beat is lost and the FSM is in IDLE. The next beat seen is treated as a first beat.
- The output register never changes while `m_axis_tvalid[out_sel]` is high and `m_axis_tready[out_sel]` is low.

## Configuration
- Macro: `RMT_DEMUX_STATS_EN`.
- Defined:
  - `stat_frames[i]` increments on each completed output handshake with `tlast` on port i.
  - `stat_drops` increments when a discarded `tlast` beat is accepted.
  - Both counters wrap modulo 2^`CNT_WIDTH`.
- Undefined: counter logic is absent, and `stat_frames` and `stat_drops` are tied to 0.

## Test plan
- Single-beat frame, `tdest`=1, all ports ready: `m_axis_tvalid`=3'b010 exactly 1 cycle after acceptance, with `tlast` set. `stat_frames[1]`=1.
- 4-beat frame, `tdest`=0, where `tdest` changes to 2 on beat 2: all 4 beats appear on port 0, in order, with data unchanged.
- Frame on port 0 followed immediately by a frame on port 2, all ports ready: 2 back-to-back frames and no idle cycle between them. Port 2's first beat follows port 0's last beat.
- 3-beat frame with `tdest`=3 and `M_COUNT`=3: no `m_axis_tvalid` asserted, `s_axis_tready` high for all 3 beats, `stat_drops`=1. The next legal frame is delivered normally.
- Hold `m_axis_tready[0]`=0 for 5 cycles mid-frame: `s_axis_tready`=0 for those cycles, and the output data stays stable. No beat is lost or duplicated.
- Assert `rst_n`=0 during beat 2 of a 4-beat frame: all outputs are 0 immediately. After release the FSM is in IDLE and a fresh single-beat frame to port 1 is delivered.

Source files
------------

// File: rtl/rmt_dest_demux_if.sv
// Bus bundle for rmt_dest_demux: one AXI-Stream slave side and M_COUNT master ports.
interface rmt_dest_demux_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned DEST_WIDTH = 2,
    parameter int unsigned M_COUNT    = 3
);
    logic [DATA_WIDTH-1:0]         s_axis_tdata;
    logic [KEEP_WIDTH-1:0]         s_axis_tkeep;
    logic                          s_axis_tvalid;
    logic                          s_axis_tready;
    logic                          s_axis_tlast;
    logic [USER_WIDTH-1:0]         s_axis_tuser;
    logic [DEST_WIDTH-1:0]         s_axis_tdest;

    logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata;
    logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep;
    logic [M_COUNT-1:0]            m_axis_tvalid;
    logic [M_COUNT-1:0]            m_axis_tready;
    logic [M_COUNT-1:0]            m_axis_tlast;
    logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser;

    // Demux side.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tdest,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    // Upstream source and downstream sinks.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tdest,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/rmt_dest_demux.sv
// Steers whole AXI-Stream frames to one of M_COUNT ports by first-beat tdest; out-of-range frames are dropped.
// Optional per-port frame / drop counters enabled by defining RMT_DEMUX_STATS_EN.
module rmt_dest_demux #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned DEST_WIDTH = 2,
    parameter int unsigned M_COUNT    = 3,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rmt_dest_demux_if.slave               bus,
    output logic [M_COUNT*CNT_WIDTH-1:0]  stat_frames,
    output logic [CNT_WIDTH-1:0]          stat_drops
);

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_e;

    state_e                state_q, state_d;
    logic [DEST_WIDTH-1:0] sel_q, sel_d;
    logic [DEST_WIDTH-1:0] out_sel_q, out_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic [USER_WIDTH-1:0] out_user_q, out_user_d;

    logic sel_ready_c;
    logic accept_c;
    logic dest_ok_c;
    logic load_c;

    // Ready of the port currently owning the output register.
    always_comb begin
        sel_ready_c = 1'b0;
        for (int i = 0; i < int'(M_COUNT); i++) begin
            if (32'(out_sel_q) == 32'(i)) sel_ready_c = bus.m_axis_tready[i];
        end
    end

    assign bus.s_axis_tready = rst_n && (!out_valid_q || sel_ready_c);
    assign accept_c          = bus.s_axis_tvalid && bus.s_axis_tready;
    assign dest_ok_c         = (32'(bus.s_axis_tdest) < M_COUNT);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        load_c      = 1'b0;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_user_d  = out_user_q;

        if (out_valid_q && sel_ready_c) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (dest_ok_c) begin
                        sel_d     = bus.s_axis_tdest;
                        out_sel_d = bus.s_axis_tdest;
                        load_c    = 1'b1;
                        state_d   = bus.s_axis_tlast ? ST_IDLE : ST_FWD;
                    end else begin
                        state_d   = bus.s_axis_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (accept_c) begin
                    out_sel_d = sel_q;
                    load_c    = 1'b1;
                    if (bus.s_axis_tlast) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept_c && bus.s_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_c) begin
            out_valid_d = 1'b1;
            out_last_d  = bus.s_axis_tlast;
            out_data_d  = bus.s_axis_tdata;
            out_keep_d  = bus.s_axis_tkeep;
            out_user_d  = bus.s_axis_tuser;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_user_q  <= out_user_d;
        end
    end

    // Payload is broadcast; only valid and last are steered.
    assign bus.m_axis_tdata = {M_COUNT{out_data_q}};
    assign bus.m_axis_tkeep = {M_COUNT{out_keep_q}};
    assign bus.m_axis_tuser = {M_COUNT{out_user_q}};

    for (genvar i = 0; i < int'(M_COUNT); i++) begin : g_port
        assign bus.m_axis_tvalid[i] = out_valid_q && (32'(out_sel_q) == 32'(i));
        assign bus.m_axis_tlast[i]  = out_valid_q && out_last_q && (32'(out_sel_q) == 32'(i));
    end

`ifdef RMT_DEMUX_STATS_EN
    logic [M_COUNT-1:0][CNT_WIDTH-1:0] frames_q, frames_d;
    logic [CNT_WIDTH-1:0]              drops_q, drops_d;
    logic                              drop_last_c;

    assign drop_last_c = accept_c && bus.s_axis_tlast &&
                         ((state_q == ST_DROP) || ((state_q == ST_IDLE) && !dest_ok_c));

    always_comb begin
        frames_d = frames_q;
        drops_d  = drops_q + CNT_WIDTH'(drop_last_c);
        for (int i = 0; i < int'(M_COUNT); i++) begin
            if (bus.m_axis_tvalid[i] && bus.m_axis_tready[i] && out_last_q)
                frames_d[i] = frames_q[i] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            frames_q <= frames_d;
            drops_q  <= drops_d;
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
`else
    assign stat_frames = '0;
    assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_rmt_dest_demux.sv
// Randomized self-checking bench for rmt_dest_demux with a per-port expected-beat scoreboard.
module tb_rmt_dest_demux;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned UW = 8;
    localparam int unsigned TW = 2;
    localparam int unsigned MC = 3;
    localparam int unsigned CW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [MC*CW-1:0] stat_frames;
    logic [CW-1:0]    stat_drops;

    rmt_dest_demux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                        .DEST_WIDTH(TW), .M_COUNT(MC)) bus ();

    rmt_dest_demux #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                     .DEST_WIDTH(TW), .M_COUNT(MC), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stat_frames (stat_frames),
        .stat_drops  (stat_drops)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    beat_t  exp_q [MC][$];
    int     exp_frames [MC];
    int     exp_drops  = 0;
    int     hs_cyc [$];
    int     hs_port [$];
    int     rdy_mode = 0;
    logic [MC-1:0] rdy_force = '1;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < int'(MC); i++) n += exp_q[i].size();
        return n;
    endfunction

    always @(posedge clk) cyc++;

    // Sink readiness: all ready, random backpressure, or a forced pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.m_axis_tready = '1;
            1:       for (int i = 0; i < int'(MC); i++) bus.m_axis_tready[i] = ($urandom_range(99) < 70);
            default: bus.m_axis_tready = rdy_force;
        endcase
    end

    // Scoreboard: every completed output handshake must match the oldest expected beat of that port.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("tvalid_onehot", DW'($countones(bus.m_axis_tvalid) <= 1), DW'(1));
            check_eq("tlast_gated", DW'(bus.m_axis_tlast & ~bus.m_axis_tvalid), '0);
            for (int i = 0; i < int'(MC); i++) begin
                if (bus.m_axis_tvalid[i] && bus.m_axis_tready[i]) begin
                    hs_cyc.push_back(cyc);
                    hs_port.push_back(i);
                    check_eq("beat_expected", DW'(exp_q[i].size() != 0), DW'(1));
                    if (exp_q[i].size() != 0) begin
                        beat_t e;
                        e = exp_q[i].pop_front();
                        check_eq("out_data", bus.m_axis_tdata[i*DW +: DW], e.data);
                        check_eq("out_keep", DW'(bus.m_axis_tkeep[i*KW +: KW]), DW'(e.keep));
                        check_eq("out_user", DW'(bus.m_axis_tuser[i*UW +: UW]), DW'(e.user));
                        check_eq("out_last", DW'(bus.m_axis_tlast[i]), DW'(e.last));
                        if (e.last) exp_frames[i]++;
                    end
                end
            end
        end
    end

    // Called at a rising edge; returns at the rising edge that accepted the final beat.
    task automatic send_frame(input int dest, input int nbeats, input int later_dest,
                              input int gap_pct, output int waits);
        beat_t b;
        bit    rdy;
        waits = 0;
        for (int n = 0; n < nbeats; n++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                #1 bus.s_axis_tvalid = 1'b0;
                @(posedge clk);
            end
            b.data = rand_data();
            b.keep = {$urandom, $urandom};
            b.user = UW'($urandom);
            b.last = (n == nbeats - 1);
            #1;
            bus.s_axis_tdata  = b.data;
            bus.s_axis_tkeep  = b.keep;
            bus.s_axis_tuser  = b.user;
            bus.s_axis_tlast  = b.last;
            bus.s_axis_tdest  = (n == 0) ? TW'(dest) : (later_dest < 0 ? TW'($urandom) : TW'(later_dest));
            bus.s_axis_tvalid = 1'b1;
            forever begin
                @(negedge clk);
                rdy = bus.s_axis_tready;
                @(posedge clk);
                if (rdy) break;
                waits++;
                if (waits > 2000) begin
                    check_eq("accept_timeout", DW'(waits), '0);
                    return;
                end
            end
            if (dest < int'(MC)) exp_q[dest].push_back(b);
            else if (b.last) exp_drops++;
        end
    endtask

    task automatic drain();
        int t = 0;
        #1 bus.s_axis_tvalid = 1'b0;
        while (pending() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain_pending", DW'(pending()), '0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_stats();
`ifdef RMT_DEMUX_STATS_EN
        for (int i = 0; i < int'(MC); i++)
            check_eq("stat_frames", DW'(stat_frames[i*CW +: CW]), DW'(exp_frames[i]));
        check_eq("stat_drops", DW'(stat_drops), DW'(exp_drops));
`else
        check_eq("stat_frames_tied", DW'(stat_frames), '0);
        check_eq("stat_drops_tied", DW'(stat_drops), '0);
`endif
    endtask

    // Single-beat frame to port 1 with the one-cycle latency checked directly.
    task automatic single_to_port1();
        int w;
        send_frame(1, 1, -1, 0, w);
        #1 bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        check_eq("lat_tvalid", DW'(bus.m_axis_tvalid), DW'(3'b010));
        check_eq("lat_tlast", DW'(bus.m_axis_tlast), DW'(3'b010));
        drain();
    endtask

    initial begin
        int w;
        logic [DW-1:0] hold;
        int seen;

        for (int i = 0; i < int'(MC); i++) exp_frames[i] = 0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tuser  = '0;
        bus.s_axis_tdest  = '0;
        bus.m_axis_tready = '1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tready", DW'(bus.s_axis_tready), '0);
        check_eq("rst_tvalid", DW'(bus.m_axis_tvalid), '0);
        check_eq("rst_tdata", bus.m_axis_tdata[DW-1:0], '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_eq("rel_tready", DW'(bus.s_axis_tready), DW'(1));
        @(posedge clk);

        single_to_port1();
        check_stats();

        // tdest changes mid-frame: must stay on port 0.
        send_frame(0, 4, 2, 0, w);
        drain();

        // Back-to-back frames on port 0 then port 2 with no bubble.
        hs_cyc.delete();
        hs_port.delete();
        send_frame(0, 2, -1, 0, w);
        send_frame(2, 2, -1, 0, w);
        drain();
        check_eq("b2b_count", DW'(hs_cyc.size()), DW'(4));
        if (hs_cyc.size() == 4) begin
            for (int k = 0; k < 3; k++) check_eq("b2b_gap", DW'(hs_cyc[k+1] - hs_cyc[k]), DW'(1));
            check_eq("b2b_port_a", DW'(hs_port[1]), DW'(0));
            check_eq("b2b_port_b", DW'(hs_port[2]), DW'(2));
        end

        // Out-of-range destination: dropped without ever stalling.
        send_frame(3, 3, -1, 0, w);
        check_eq("drop_no_stall", DW'(w), '0);
        drain();
        check_stats();
        send_frame(1, 2, -1, 0, w);
        drain();

        // Port 0 stalls for 5 cycles mid-frame.
        rdy_force = 3'b110;
        rdy_mode  = 2;
        @(posedge clk);
        fork
            send_frame(0, 4, -1, 0, w);
            begin
                seen = 0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = bus.m_axis_tvalid[0];
                end
                check_eq("stall_seen", DW'(seen), DW'(1));
                hold = bus.m_axis_tdata[DW-1:0];
                for (int t = 0; t < 5; t++) begin
                    if (t > 0) @(negedge clk);
                    check_eq("stall_tready", DW'(bus.s_axis_tready), '0);
                    check_eq("stall_data", bus.m_axis_tdata[DW-1:0], hold);
                end
                rdy_force = '1;
            end
        join
        drain();
        rdy_mode = 0;

        // Reset during beat 2 of a 4-beat frame.
        begin
            beat_t b;
            b.data = rand_data(); b.keep = '1; b.user = 8'h5a; b.last = 1'b0;
            #1;
            bus.s_axis_tdata = b.data; bus.s_axis_tkeep = b.keep; bus.s_axis_tuser = b.user;
            bus.s_axis_tlast = 1'b0;   bus.s_axis_tdest = 2'd0;   bus.s_axis_tvalid = 1'b1;
            @(posedge clk);
            exp_q[0].push_back(b);
            #1 bus.s_axis_tdata = rand_data();
            @(negedge clk);
            #1 rst_n = 1'b0;
            #1;
            check_eq("mid_rst_tvalid", DW'(bus.m_axis_tvalid), '0);
            check_eq("mid_rst_tlast", DW'(bus.m_axis_tlast), '0);
            check_eq("mid_rst_tdata", bus.m_axis_tdata[DW-1:0], '0);
            check_eq("mid_rst_tkeep", DW'(bus.m_axis_tkeep), '0);
            check_eq("mid_rst_tuser", DW'(bus.m_axis_tuser), '0);
            check_eq("mid_rst_tready", DW'(bus.s_axis_tready), '0);
            check_eq("mid_rst_stats", DW'(stat_frames) | DW'(stat_drops), '0);
            bus.s_axis_tvalid = 1'b0;
            for (int i = 0; i < int'(MC); i++) begin
                exp_q[i].delete();
                exp_frames[i] = 0;
            end
            exp_drops = 0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            #1 check_eq("mid_rel_tready", DW'(bus.s_axis_tready), DW'(1));
            @(posedge clk);
            single_to_port1();
            check_stats();
        end

        // Randomized traffic with random sink backpressure.
        rdy_mode = 1;
        for (int f = 0; f < 150; f++)
            send_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), -1, 30, w);
        rdy_mode = 0;
        drain();
        check_stats();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
